// File: rtl/garbled_table_packer.sv
// Garbled-table packer: captures AND-gate results on the rising edge of in_valid,
// buffers up to DEPTH records and streams each as 64-bit words, MSB-first.
module garbled_table_packer #(
  parameter int unsigned LABEL_W = 80,
  parameter int unsigned GID_W   = 64,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [GID_W-1:0]   gid_in,
  input  logic [LABEL_W-1:0] gc_in,
  input  logic [LABEL_W-1:0] t01_in,
  input  logic [LABEL_W-1:0] t10_in,
  input  logic [LABEL_W-1:0] t11_in,
  output logic               in_ready,
  output logic [LABEL_W-1:0] gc_out,
  output logic               gc_out_valid,
  output logic [63:0]        tx_data,
  output logic               tx_valid,
  output logic               tx_last,
  input  logic               tx_ready,
  output logic               overflow,
  output logic [CNT_W-1:0]   drop_count
);

  localparam int unsigned REC_W  = GID_W + 3 * LABEL_W;
  localparam int unsigned NWORDS = (REC_W + 63) / 64;
  localparam int unsigned PAD_W  = NWORDS * 64;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNTQ_W = $clog2(DEPTH + 1);
  localparam int unsigned WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t              state_q, state_d;
  logic [REC_W-1:0]    buf_q [DEPTH];
  logic [REC_W-1:0]    buf_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTQ_W-1:0]   count_q, count_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic                in_valid_q, in_valid_d;
  logic                in_ready_q, in_ready_d;
  logic [LABEL_W-1:0]  gc_out_q, gc_out_d;
  logic                gc_out_valid_q, gc_out_valid_d;
  logic [63:0]         tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                tx_last_q, tx_last_d;
  logic                overflow_q, overflow_d;
  logic [CNT_W-1:0]    drop_count_q, drop_count_d;

  logic                cap_edge, full, push, drop, accept, last_acc;
  logic [REC_W-1:0]    rec_in;

  assign rec_in = {gid_in, t01_in, t10_in, t11_in};

  // Word idx of a record, record left-aligned and zero-padded at the LSB end.
  function automatic logic [63:0] word_of(input logic [REC_W-1:0] rec,
                                          input logic [WIDX_W-1:0] idx);
    logic [PAD_W-1:0] p;
    int unsigned      base;
    p    = PAD_W'(rec) << (PAD_W - REC_W);
    base = (NWORDS - 1 - 32'(idx)) * 64;
    return p[base +: 64];
  endfunction

  // Capture, buffer bookkeeping, stream FSM and registered output values.
  always_comb begin
    state_d        = state_q;
    buf_d          = buf_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    widx_d         = widx_q;
    in_valid_d     = in_valid;
    gc_out_d       = gc_out_q;
    gc_out_valid_d = 1'b0;
    overflow_d     = overflow_q;
    drop_count_d   = drop_count_q;

    cap_edge = in_valid & ~in_valid_q;
    full     = (count_q == CNTQ_W'(DEPTH));
    push     = cap_edge & ~full;
    drop     = cap_edge & full;
    accept   = tx_valid_q & tx_ready;
    last_acc = accept & (widx_q == WIDX_W'(NWORDS - 1));

    if (push) begin
      buf_d[wr_ptr_q] = rec_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      gc_out_d        = gc_in;
      gc_out_valid_d  = 1'b1;
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != {CNT_W{1'b1}}) drop_count_d = drop_count_q + CNT_W'(1);
    end

    if (accept) begin
      if (last_acc) begin
        widx_d   = '0;
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        widx_d = widx_q + WIDX_W'(1);
      end
    end

    count_d = count_q + CNTQ_W'(push) - CNTQ_W'(last_acc);

    case (state_q)
      S_IDLE:  if (count_d != '0) state_d = S_SEND;
      S_SEND:  if (last_acc && (count_d == '0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    tx_valid_d = (state_d == S_SEND);
    tx_data_d  = tx_valid_d ? word_of(buf_d[rd_ptr_d], widx_d) : 64'h0;
    tx_last_d  = tx_valid_d && (widx_d == WIDX_W'(NWORDS - 1));
    in_ready_d = (count_d != CNTQ_W'(DEPTH));
  end

  // State and output registers; reset aborts any record in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      buf_q          <= '{default: '0};
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      widx_q         <= '0;
      in_valid_q     <= 1'b0;
      in_ready_q     <= 1'b1;
      gc_out_q       <= '0;
      gc_out_valid_q <= 1'b0;
      tx_data_q      <= '0;
      tx_valid_q     <= 1'b0;
      tx_last_q      <= 1'b0;
      overflow_q     <= 1'b0;
      drop_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      buf_q          <= buf_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      widx_q         <= widx_d;
      in_valid_q     <= in_valid_d;
      in_ready_q     <= in_ready_d;
      gc_out_q       <= gc_out_d;
      gc_out_valid_q <= gc_out_valid_d;
      tx_data_q      <= tx_data_d;
      tx_valid_q     <= tx_valid_d;
      tx_last_q      <= tx_last_d;
      overflow_q     <= overflow_d;
      drop_count_q   <= drop_count_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign gc_out       = gc_out_q;
  assign gc_out_valid = gc_out_valid_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign tx_last      = tx_last_q;
  assign overflow     = overflow_q;
  assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_garbled_table_packer.sv
// Bench for garbled_table_packer: vector table, directed corner sequences and
// randomized traffic against a word-queue reference model.
module tb_garbled_table_packer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] gid_in = '0;
  logic [79:0] gc_in = '0, t01_in = '0, t10_in = '0, t11_in = '0;
  logic        in_ready;
  logic [79:0] gc_out;
  logic        gc_out_valid;
  logic [63:0] tx_data;
  logic        tx_valid, tx_last;
  logic        tx_ready = 1'b0;
  logic        overflow;
  logic [15:0] drop_count;

  garbled_table_packer dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .gid_in(gid_in),
    .gc_in(gc_in), .t01_in(t01_in), .t10_in(t10_in), .t11_in(t11_in),
    .in_ready(in_ready), .gc_out(gc_out), .gc_out_valid(gc_out_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pending output words, record occupancy, error counters.
  typedef struct { logic [63:0] d; logic l; } wd_t;
  wd_t         wq[$];
  int          m_recs;
  bit          m_prev, m_ovf, m_gcv;
  logic [15:0] m_dcnt;
  logic [79:0] m_gc;
  int          acc_cnt;

  typedef struct {
    logic iv; logic rdy; logic ev; logic el; logic [63:0] ed; logic egcv;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    wq.delete();
    m_recs = 0; m_prev = 0; m_ovf = 0; m_gcv = 0; m_dcnt = '0; m_gc = '0;
  endtask

  task automatic model_edge();
    bit           full;
    wd_t          w;
    logic [319:0] r;
    full  = (m_recs == DEPTH);
    if (wq.size() > 0 && tx_ready) begin
      if (wq[0].l) m_recs--;
      w = wq.pop_front();
    end
    m_gcv = 0;
    if (in_valid && !m_prev) begin
      if (full) begin
        m_ovf = 1;
        if (m_dcnt != 16'hFFFF) m_dcnt++;
      end else begin
        r = {gid_in, t01_in, t10_in, t11_in, 16'h0};
        for (int i = 0; i < 5; i++) begin
          w.d = r[319 - 64*i -: 64];
          w.l = (i == 4);
          wq.push_back(w);
        end
        m_recs++;
        m_gcv = 1;
        m_gc  = gc_in;
      end
    end
    m_prev = in_valid;
  endtask

  task automatic model_check();
    chk("tx_valid", 128'(tx_valid), 128'(wq.size() > 0));
    if (wq.size() > 0) begin
      chk("tx_data", 128'(tx_data), 128'(wq[0].d));
      chk("tx_last", 128'(tx_last), 128'(wq[0].l));
    end
    chk("in_ready", 128'(in_ready), 128'(m_recs != DEPTH));
    chk("gc_out_valid", 128'(gc_out_valid), 128'(m_gcv));
    chk("gc_out", 128'(gc_out), 128'(m_gc));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    chk("drop_count", 128'(drop_count), 128'(m_dcnt));
  endtask

  // One clock: model the edge with the current inputs, then compare after it.
  task automatic step();
    if (tx_valid && tx_ready) acc_cnt++;
    model_edge();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic rand_data();
    gid_in = {$urandom, $urandom};
    gc_in  = 80'({$urandom, $urandom, $urandom});
    t01_in = 80'({$urandom, $urandom, $urandom});
    t10_in = 80'({$urandom, $urandom, $urandom});
    t11_in = 80'({$urandom, $urandom, $urandom});
  endtask

  initial begin
    vec_t tv[6];
    int   gcv_cnt, last_cnt, run, maxrun, vcnt;
    bit   raised;

    // Reset state
    #1 reset_n = 1'b0;
    #2;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_tx_valid", 128'(tx_valid), 128'(0));
    chk("rst_overflow", 128'(overflow), 128'(0));
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();

    // Test 1: single gate via vector table
    gid_in = 64'h1;
    gc_in  = 80'h1234_5678_9ABC_DEF0_1357;
    t01_in = {20{4'hA}};
    t10_in = {20{4'hB}};
    t11_in = {20{4'hC}};
    tv[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 64'h0000_0000_0000_0001, 1'b1};
    tv[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0};
    tv[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'hAAAA_BBBB_BBBB_BBBB, 1'b0};
    tv[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'hBBBB_BBBB_CCCC_CCCC, 1'b0};
    tv[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 64'hCCCC_CCCC_CCCC_0000, 1'b0};
    tv[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      in_valid = tv[i].iv;
      tx_ready = tv[i].rdy;
      step();
      chk("t1_valid", 128'(tx_valid), 128'(tv[i].ev));
      if (tv[i].ev) begin
        chk("t1_data", 128'(tx_data), 128'(tv[i].ed));
        chk("t1_last", 128'(tx_last), 128'(tv[i].el));
      end
      chk("t1_gcv", 128'(gc_out_valid), 128'(tv[i].egcv));
    end
    chk("t1_gc", 128'(gc_out), 128'(80'h1234_5678_9ABC_DEF0_1357));

    // Test 2: alternating tx_ready, exactly five accepts
    rand_data();
    acc_cnt  = 0;
    in_valid = 1'b1; tx_ready = 1'b0; step();
    in_valid = 1'b0;
    for (int k = 0; k < 14; k++) begin
      tx_ready = (k % 2 == 0);
      step();
    end
    chk("t2_accepts", 128'(acc_cnt), 128'(5));

    // Test 4: in_valid held high for 20 cycles
    rand_data();
    tx_ready = 1'b1; gcv_cnt = 0; last_cnt = 0;
    in_valid = 1'b1;
    for (int k = 0; k < 23; k++) begin
      if (k == 20) in_valid = 1'b0;
      step();
      if (gc_out_valid) gcv_cnt++;
      if (tx_valid && tx_last) last_cnt++;
    end
    chk("t4_captures", 128'(gcv_cnt), 128'(1));
    chk("t4_records", 128'(last_cnt), 128'(1));

    // Test 5: back-to-back records, third captured on the pop of the second
    run = 0; maxrun = 0; vcnt = 0; last_cnt = 0; raised = 0;
    for (int k = 0; k < 25; k++) begin
      rand_data();
      in_valid = (k == 0) || (k == 2);
      if (last_cnt == 2 && !raised) begin
        in_valid = 1'b1;
        raised   = 1;
      end
      step();
      if (tx_valid) begin
        vcnt++; run++;
        if (run > maxrun) maxrun = run;
        if (tx_last) last_cnt++;
      end else run = 0;
    end
    in_valid = 1'b0;
    chk("t5_valid_cycles", 128'(vcnt), 128'(15));
    chk("t5_max_run", 128'(maxrun), 128'(15));
    chk("t5_lasts", 128'(last_cnt), 128'(3));

    // Test 3: three edges while stalled, third dropped
    step();
    tx_ready = 1'b0; gcv_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      rand_data();
      in_valid = (k % 2 == 0);
      step();
      if (gc_out_valid) gcv_cnt++;
    end
    chk("t3_in_ready", 128'(in_ready), 128'(0));
    chk("t3_overflow", 128'(overflow), 128'(1));
    chk("t3_drop_count", 128'(drop_count), 128'(1));
    chk("t3_captures", 128'(gcv_cnt), 128'(2));

    // Test 6: reset asserted while W2 is presented
    tx_ready = 1'b1;
    step(); step();
    #2 reset_n = 1'b0;
    #1;
    chk("t6_tx_valid", 128'(tx_valid), 128'(0));
    chk("t6_tx_data", 128'(tx_data), 128'(0));
    chk("t6_in_ready", 128'(in_ready), 128'(1));
    chk("t6_overflow", 128'(overflow), 128'(0));
    chk("t6_drop_count", 128'(drop_count), 128'(0));
    chk("t6_gc_out", 128'(gc_out), 128'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    gid_in = 64'h1234;
    in_valid = 1'b1; step();
    chk("t6_restart_w0", 128'(tx_data), 128'(64'h1234));
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();

    // Randomized traffic, then a heavily stalled phase to force drops
    for (int k = 0; k < 1500; k++) begin
      rand_data();
      in_valid = 1'($urandom % 2);
      tx_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    for (int k = 0; k < 500; k++) begin
      rand_data();
      in_valid = 1'($urandom % 2);
      tx_ready = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
